// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional baud-rate generator with oversample, bit-centre and bit-boundary strobes.
// The interval between oversample ticks is div_int (minimum 2) plus a one-cycle stretch that
// a phase accumulator adds on carry, so the long-run tick period is div_int + div_frac/2^FRAC_W.
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   enable     high = run, low = freeze all timing state
//   load       one-cycle strobe: capture div_int/div_frac and restart timing
//   div_int    integer clk cycles per oversample tick
//   div_frac   fractional cycles per tick, units of 1/2^FRAC_W
//   os_tick    single-cycle oversample strobe
//   mid_tick   single-cycle strobe at bit centre
//   baud_tick  single-cycle strobe at bit boundary
//   sub_cnt    oversample index within the current bit
module baud_gen_frac #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FRAC_W     = 4,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          load,
    input  logic [CNT_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    output logic                          os_tick,
    output logic                          mid_tick,
    output logic                          baud_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] sub_cnt
);

    localparam int unsigned SUB_W  = $clog2(OVERSAMPLE);
    localparam int unsigned CNT_FW = CNT_W + 1;
    localparam int unsigned HALF   = OVERSAMPLE / 2;

    logic [CNT_W-1:0]  div_int_q;
    logic [FRAC_W-1:0] div_frac_q;
    logic [CNT_W:0]    cnt;
    logic [FRAC_W-1:0] acc;
    logic              extra;

    logic [CNT_W:0]    eff_int_c;
    logic [CNT_W:0]    period_m1_c;
    logic [FRAC_W:0]   acc_sum_c;
    logic              term_c;
    logic [SUB_W-1:0]  sub_nxt_c;

    // Interval arithmetic; cnt is one bit wider so a period of 2^CNT_W fits.
    always_comb begin
        eff_int_c   = (div_int_q < CNT_W'(2)) ? CNT_FW'(2) : {1'b0, div_int_q};
        period_m1_c = eff_int_c + CNT_FW'(extra) - CNT_FW'(1);
        acc_sum_c   = {1'b0, acc} + {1'b0, div_frac_q};
        term_c      = (cnt == period_m1_c);
        sub_nxt_c   = sub_cnt + SUB_W'(1);
    end

    // Timing state and registered strobes; load outranks a coincident terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_int_q  <= CNT_W'(2);
            div_frac_q <= '0;
            cnt        <= '0;
            acc        <= '0;
            extra      <= 1'b0;
            sub_cnt    <= '0;
            os_tick    <= 1'b0;
            mid_tick   <= 1'b0;
            baud_tick  <= 1'b0;
        end else begin
            os_tick   <= 1'b0;
            mid_tick  <= 1'b0;
            baud_tick <= 1'b0;
            if (load) begin
                div_int_q  <= div_int;
                div_frac_q <= div_frac;
                cnt        <= '0;
                acc        <= '0;
                extra      <= 1'b0;
                sub_cnt    <= '0;
            end else if (enable) begin
                if (term_c) begin
                    cnt       <= '0;
                    acc       <= acc_sum_c[FRAC_W-1:0];
                    extra     <= acc_sum_c[FRAC_W];
                    os_tick   <= 1'b1;
                    sub_cnt   <= sub_nxt_c;
                    mid_tick  <= (sub_nxt_c == SUB_W'(HALF));
                    baud_tick <= (sub_cnt == SUB_W'(OVERSAMPLE - 1));
                end else begin
                    cnt <= cnt + CNT_FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac. The reference model places the k-th oversample tick
// after a load at active cycle k*D + floor((k-1)*F / 2^FRAC_W), with D = max(div_int, 2).
module tb_baud_gen_frac;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned FRAC_W = 4;
    localparam int unsigned OS     = 4;
    localparam int unsigned SUB_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              load;
    logic [CNT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              os_tick;
    logic              mid_tick;
    logic              baud_tick;
    logic [SUB_W-1:0]  sub_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    longint m_d, m_f, m_act, m_ticks;
    logic             e_os, e_mid, e_baud;
    logic [SUB_W-1:0] e_sub;

    baud_gen_frac #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .div_int(div_int), .div_frac(div_frac),
        .os_tick(os_tick), .mid_tick(mid_tick), .baud_tick(baud_tick), .sub_cnt(sub_cnt)
    );

    always #5 clk = ~clk;

    function automatic longint t_of(longint k);
        return k * m_d + (((k - 1) * m_f) >>> FRAC_W);
    endfunction

    task automatic model_load(int di, int df);
        m_d     = (di < 2) ? 2 : di;
        m_f     = df;
        m_act   = 0;
        m_ticks = 0;
        e_os = 1'b0; e_mid = 1'b0; e_baud = 1'b0; e_sub = '0;
    endtask

    function automatic logic next_is_term();
        return (m_act + 1) == t_of(m_ticks + 1);
    endfunction

    // One clock edge; model advances from the inputs seen at that edge.
    task automatic step();
        @(posedge clk);
        if (load) begin
            model_load(int'(div_int), int'(div_frac));
        end else begin
            e_os = 1'b0; e_mid = 1'b0; e_baud = 1'b0;
            if (enable) begin
                m_act++;
                if (m_act == t_of(m_ticks + 1)) begin
                    m_ticks++;
                    e_os   = 1'b1;
                    e_mid  = (m_ticks % OS) == (OS / 2);
                    e_baud = (m_ticks % OS) == 0;
                end
            end
        end
        e_sub = SUB_W'(m_ticks % OS);
        #1;
    endtask

    task automatic do_load(int di, int df);
        div_int  = CNT_W'(di);
        div_frac = FRAC_W'(df);
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({os_tick, mid_tick, baud_tick, sub_cnt} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 00000", {os_tick, mid_tick, baud_tick, sub_cnt});
        end
        reset = 1'b1;
        model_load(2, 0);
        for (int i = 0; i < 12; i++) begin
            step();
            n_tests++;
            if ({os_tick, mid_tick, baud_tick, sub_cnt} !== {e_os, e_mid, e_baud, e_sub}) begin
                n_fail++;
                $display("FAIL reset_release cyc %0d: got %b want %b", i,
                         {os_tick, mid_tick, baud_tick, sub_cnt}, {e_os, e_mid, e_baud, e_sub});
            end
        end
    endtask

    task automatic test_integer();
        int bauds = 0;
        do_load(5, 0);
        for (int i = 0; i < 45; i++) begin
            step();
            if (baud_tick) bauds++;
            n_tests++;
            if ({os_tick, mid_tick, baud_tick, sub_cnt} !== {e_os, e_mid, e_baud, e_sub}) begin
                n_fail++;
                $display("FAIL integer cyc %0d: got %b want %b", i,
                         {os_tick, mid_tick, baud_tick, sub_cnt}, {e_os, e_mid, e_baud, e_sub});
            end
        end
        n_tests++;
        if (bauds != 2) begin
            n_fail++;
            $display("FAIL integer_baud_count: got %0d want 2", bauds);
        end
    endtask

    task automatic test_frac();
        int ticks = 0;
        int at16  = -1;
        do_load(5, 8);
        for (int i = 1; i <= 95; i++) begin
            step();
            if (os_tick) begin
                ticks++;
                if (ticks == 16) at16 = i;
            end
            n_tests++;
            if ({os_tick, mid_tick, baud_tick, sub_cnt} !== {e_os, e_mid, e_baud, e_sub}) begin
                n_fail++;
                $display("FAIL frac cyc %0d: got %b want %b", i,
                         {os_tick, mid_tick, baud_tick, sub_cnt}, {e_os, e_mid, e_baud, e_sub});
            end
        end
        n_tests++;
        if (at16 != 87) begin
            n_fail++;
            $display("FAIL frac_16_intervals: got %0d want 87", at16);
        end
    endtask

    task automatic test_enable_gap();
        int wait_c = 0;
        do_load(5, 0);
        repeat (7) step();
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            n_tests++;
            if ({os_tick, mid_tick, baud_tick, sub_cnt} !== {3'b000, e_sub}) begin
                n_fail++;
                $display("FAIL enable_gap cyc %0d: got %b want %b", i,
                         {os_tick, mid_tick, baud_tick, sub_cnt}, {3'b000, e_sub});
            end
        end
        enable = 1'b1;
        while (wait_c < 20) begin
            step();
            wait_c++;
            if (os_tick) break;
        end
        n_tests++;
        if (!os_tick || wait_c != 3) begin
            n_fail++;
            $display("FAIL enable_resume: got %0d cycles want 3", wait_c);
        end
    endtask

    task automatic test_load_terminal();
        int guard  = 0;
        int wait_c = 0;
        do_load(4, 5);
        repeat (9) step();
        while (!next_is_term() && guard < 50) begin
            step();
            guard++;
        end
        n_tests++;
        if (!next_is_term()) begin
            n_fail++;
            $display("FAIL load_term_setup: terminal not reached within 50 cycles");
        end
        do_load(3, 0);
        n_tests++;
        if ({os_tick, mid_tick, baud_tick, sub_cnt} !== 5'b0) begin
            n_fail++;
            $display("FAIL load_at_terminal: got %b want 00000", {os_tick, mid_tick, baud_tick, sub_cnt});
        end
        while (wait_c < 20) begin
            step();
            wait_c++;
            if (os_tick) break;
        end
        n_tests++;
        if (!os_tick || wait_c != 3) begin
            n_fail++;
            $display("FAIL load_term_next: got %0d cycles want 3", wait_c);
        end
    endtask

    task automatic test_small_div();
        for (int d = 0; d < 2; d++) begin
            int bauds = 0;
            do_load(d, 0);
            for (int i = 1; i <= 40; i++) begin
                step();
                if (baud_tick) bauds++;
                n_tests++;
                if (os_tick !== ((i % 2) == 0)) begin
                    n_fail++;
                    $display("FAIL small_div%0d cyc %0d: os_tick got %b want %b", d, i, os_tick, (i % 2) == 0);
                end
                n_tests++;
                if (baud_tick !== ((i % (2 * OS)) == 0)) begin
                    n_fail++;
                    $display("FAIL small_div%0d cyc %0d: baud_tick got %b want %b", d, i,
                             baud_tick, (i % (2 * OS)) == 0);
                end
            end
            n_tests++;
            if (bauds != 5) begin
                n_fail++;
                $display("FAIL small_div%0d_baud_count: got %0d want 5", d, bauds);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int n;
            enable = ($urandom_range(0, 3) != 0);
            do_load(int'($urandom_range(0, 9)), int'($urandom_range(0, 15)));
            n = int'($urandom_range(20, 90));
            for (int i = 0; i < n; i++) begin
                enable = ($urandom_range(0, 9) != 0);
                step();
                n_tests++;
                if ({os_tick, mid_tick, baud_tick, sub_cnt} !== {e_os, e_mid, e_baud, e_sub}) begin
                    n_fail++;
                    $display("FAIL random it %0d cyc %0d: got %b want %b", it, i,
                             {os_tick, mid_tick, baud_tick, sub_cnt}, {e_os, e_mid, e_baud, e_sub});
                end
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        do_load(7, 3);
        repeat (15) step();
        #3;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({os_tick, mid_tick, baud_tick, sub_cnt} !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b want 00000", {os_tick, mid_tick, baud_tick, sub_cnt});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_load(2, 0);
        for (int i = 0; i < 12; i++) begin
            step();
            n_tests++;
            if ({os_tick, mid_tick, baud_tick, sub_cnt} !== {e_os, e_mid, e_baud, e_sub}) begin
                n_fail++;
                $display("FAIL async_restart cyc %0d: got %b want %b", i,
                         {os_tick, mid_tick, baud_tick, sub_cnt}, {e_os, e_mid, e_baud, e_sub});
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        div_int  = '0;
        div_frac = '0;
        model_load(2, 0);
        #12;
        test_reset();
        test_integer();
        test_frac();
        test_enable_gap();
        test_load_terminal();
        test_small_div();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
